// File: rtl/parsed_msg_fifo.sv
// Buffers parsed ITCH events (type, order_ref) for the order-book stage.
// Events that arrive while the FIFO is full are dropped and counted; a per-type mask filters input.
module parsed_msg_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     parsed_valid,
    input  logic [3:0]               parsed_type,
    input  logic [63:0]              order_ref,
    input  logic [15:0]              type_mask,
    input  logic                     clr_stats,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_type,
    output logic [63:0]              out_order_ref,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [3:0]    mem_type [DEPTH];
    logic [63:0]   mem_ref  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] fill, fill_next;
    logic          accept, pop, push, drop, full;
    logic [CNT_W-1:0] cnt_base, cnt_next;
    logic          ovf_next;

    // Output handshake: the head entry transfers on any rising edge where out_valid && out_ready;
    // out_valid never drops and the head never changes until that transfer happens.
    assign full   = (fill == FW'(DEPTH));
    assign accept = parsed_valid && type_mask[parsed_type];
    assign pop    = out_valid && out_ready;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    always_comb begin
        fill_next = fill;
        case ({push, pop})
            2'b10:   fill_next = fill + FW'(1);
            2'b01:   fill_next = fill - FW'(1);
            default: fill_next = fill;
        endcase
    end

    // clr_stats takes effect before a same-cycle drop is counted.
    always_comb begin
        cnt_base = clr_stats ? '0 : drop_count;
        cnt_next = cnt_base;
        ovf_next = clr_stats ? 1'b0 : overflow;
        if (drop) begin
            ovf_next = 1'b1;
            if (cnt_base != '1) cnt_next = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fill       <= fill_next;
            out_valid  <= (fill_next != '0);
            overflow   <= ovf_next;
            drop_count <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_type[wr_ptr] <= parsed_type;
            mem_ref[wr_ptr]  <= order_ref;
        end
    end

    assign out_type      = out_valid ? mem_type[rd_ptr] : 4'd0;
    assign out_order_ref = out_valid ? mem_ref[rd_ptr]  : 64'd0;
    assign fill_level    = fill;

endmodule

// File: tb/tb_parsed_msg_fifo.sv
// Bench for parsed_msg_fifo: queue-based reference model checked every cycle, directed cases
// with literal expectations, then randomized traffic.
module tb_parsed_msg_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        parsed_valid = 1'b0;
    logic [3:0]  parsed_type = 4'd0;
    logic [63:0] order_ref = 64'd0;
    logic [15:0] type_mask = 16'hFFFF;
    logic        clr_stats = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [3:0]  out_type;
    logic [63:0] out_order_ref;
    logic [4:0]  fill_level;
    logic        overflow;
    logic [CNT_W-1:0] drop_count;

    int total = 0;
    int bad = 0;

    parsed_msg_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .parsed_valid(parsed_valid), .parsed_type(parsed_type),
        .order_ref(order_ref), .type_mask(type_mask), .clr_stats(clr_stats),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_order_ref(out_order_ref), .fill_level(fill_level), .overflow(overflow),
        .drop_count(drop_count)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a queue of {type, ref} plus drop statistics
    logic [67:0] exp_q[$];
    int  m_drop;
    bit  m_ovf;

    always @(posedge clk or posedge rst) begin
        bit acc, pp;
        if (rst) begin
            exp_q.delete();
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            acc = parsed_valid && type_mask[parsed_type];
            pp  = (exp_q.size() != 0) && out_ready;
            if (clr_stats) begin
                m_drop = 0;
                m_ovf  = 0;
            end
            if (pp) void'(exp_q.pop_front());
            if (acc) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({parsed_type, order_ref});
                else begin
                    m_ovf = 1;
                    if (m_drop < CNT_MAX) m_drop++;
                end
            end
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("m_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            check("m_out_type", {60'd0, out_type}, exp_q.size() != 0 ? {60'd0, exp_q[0][67:64]} : 64'd0);
            check("m_out_ref", out_order_ref, exp_q.size() != 0 ? exp_q[0][63:0] : 64'd0);
            check("m_fill", {59'd0, fill_level}, 64'(exp_q.size()));
            check("m_overflow", {63'd0, overflow}, {63'd0, m_ovf});
            check("m_drop", {60'd0, drop_count}, 64'(m_drop));
        end
    end

    // driver tasks
    task automatic step(input logic pv, input logic [3:0] t, input logic [63:0] r,
                        input logic rdy, input logic clr);
        @(negedge clk);
        parsed_valid = pv;
        parsed_type  = t;
        order_ref    = r;
        out_ready    = rdy;
        clr_stats    = clr;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 4'd0, 64'd0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        parsed_valid = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_fill", {59'd0, fill_level}, 64'd0);
        check("rst_type", {60'd0, out_type}, 64'd0);
        check("rst_ref", out_order_ref, 64'd0);
        check("rst_drop", {60'd0, drop_count}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);

        // first event, one-cycle latency
        step(1'b1, 4'd1, 64'h1122334455667788, 1'b0, 1'b0);
        idle(1'b0);
        check("first_valid", {63'd0, out_valid}, 64'd1);
        check("first_type", {60'd0, out_type}, 64'd1);
        check("first_ref", out_order_ref, 64'h1122334455667788);
        check("first_fill", {59'd0, fill_level}, 64'd1);

        // mask filtering
        do_reset();
        type_mask = 16'hFFFD;
        step(1'b1, 4'd1, 64'h10, 1'b0, 1'b0);
        step(1'b1, 4'd2, 64'h20, 1'b0, 1'b0);
        idle(1'b0);
        check("mask_fill", {59'd0, fill_level}, 64'd1);
        check("mask_type", {60'd0, out_type}, 64'd2);
        check("mask_drop", {60'd0, drop_count}, 64'd0);
        type_mask = 16'hFFFF;

        // overflow by one, then drain in order
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, 4'd3, 64'(i), 1'b0, 1'b0);
        idle(1'b0);
        check("ovf_fill", {59'd0, fill_level}, 64'd16);
        check("ovf_drop", {60'd0, drop_count}, 64'd1);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        for (int i = 1; i <= 16; i++) begin
            check("drain_ref", out_order_ref, 64'(i));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("drain_empty", {63'd0, out_valid}, 64'd0);

        // full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 4'd4, 64'h100 + 64'(i), 1'b0, 1'b0);
        step(1'b1, 4'd5, 64'hAA, 1'b1, 1'b0);
        idle(1'b0);
        check("fullpp_fill", {59'd0, fill_level}, 64'd16);
        check("fullpp_drop", {60'd0, drop_count}, 64'd0);
        for (int i = 2; i <= 17; i++) begin
            check("fullpp_ref", out_order_ref, i == 17 ? 64'hAA : 64'h100 + 64'(i));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;

        // clr_stats coinciding with a drop, then a lone clr_stats
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, 4'd6, 64'(i), 1'b0, 1'b0);
        step(1'b1, 4'd6, 64'h99, 1'b0, 1'b1);
        idle(1'b0);
        check("clrdrop_cnt", {60'd0, drop_count}, 64'd1);
        check("clrdrop_ovf", {63'd0, overflow}, 64'd1);
        step(1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        idle(1'b0);
        check("clr_cnt", {60'd0, drop_count}, 64'd0);
        check("clr_ovf", {63'd0, overflow}, 64'd0);

        // streaming across pointer wrap, then async reset mid-run
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 4'(i), 64'd1000 + 64'(i), 1'b1, 1'b0);
            if (i > 0) begin
                check("stream_ref", out_order_ref, 64'd1000 + 64'(i - 1));
                check("stream_fill", {59'd0, fill_level}, 64'd1);
            end
        end
        #2 rst = 1'b1;
        #1;
        check("async_valid", {63'd0, out_valid}, 64'd0);
        check("async_fill", {59'd0, fill_level}, 64'd0);
        @(negedge clk);
        parsed_valid = 1'b0;
        rst = 1'b0;
        step(1'b1, 4'd7, 64'h77, 1'b0, 1'b0);
        idle(1'b0);
        check("post_rst_ref", out_order_ref, 64'h77);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) type_mask = 16'($urandom) | 16'h0001;
            @(negedge clk);
            parsed_valid = ($urandom_range(0, 3) != 0);
            parsed_type  = 4'($urandom_range(0, 15));
            order_ref    = {32'($urandom), 32'($urandom)};
            out_ready    = (i / 200) % 2 == 0 ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            clr_stats    = ($urandom_range(0, 99) == 0);
        end
        idle(1'b0);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
